module_spi_rx_deserializer: RTL and testbench
=============================================

// Module: module_spi_rx_deserializer
// PURPOSE
// - Parametrised SPI slave receive path: synchronises raw sclk/cs_n/mosi, detects the sample edge per SPI mode,
//   and deserialises WIDTH-bit words with selectable bit order.
// - Holds each completed word in a 1-entry output register with valid/ready handshake; flags overrun and short frames.
// - Sits between the SPI pins and the register/command decoder; supersedes the fixed 8-bit rx shift register.
// PARAMETERS
// - WIDTH        8   bits per word (>=2)
// - MSB_FIRST    1   1: first received bit lands in data_o[WIDTH-1]; 0: in data_o[0]
// - CPOL         0   sclk idle level
// - CPHA         0   0: sample on leading edge; 1: sample on trailing edge
// - SYNC_STAGES  2   synchroniser depth on sclk_i, cs_n_i, mosi_i (>=2)
// PORTS
// - clk_i        in   1                  system clock; single clock domain
// - rst_i        in   1                  synchronous, active-high reset
// - sclk_i       in   1                  SPI clock, asynchronous to clk_i
// - cs_n_i       in   1                  SPI chip select, active low, asynchronous
// - mosi_i       in   1                  SPI serial data, asynchronous
// - data_o       out  WIDTH              received word (holding register)
// - valid_o      out  1                  data_o holds an unconsumed word
// - ready_i      in   1                  consumer accepts word when valid_o & ready_i
// - overrun_o    out  1                  1-cycle pulse: word completed while holding register full, not accepted
// - frame_err_o  out  1                  1-cycle pulse: cs_n deasserted with partial word (bit_cnt != 0)
// - busy_o       out  1                  FSM in SHIFT state
// BEHAVIOUR
// - Reset: data_o=0, valid_o=0, overrun_o=0, frame_err_o=0, busy_o=0, FSM=IDLE, bit_cnt=0, shift reg=0;
//   sync flops preset to idle values (sclk=CPOL, cs_n=1, mosi=0) so no false edges after reset.
// - Sample edge: rising when CPOL==CPHA (modes 0,3), falling otherwise (modes 1,2).
//   Edge = synced sclk vs. its 1-cycle delayed copy; mosi sampled from its synced value in the same cycle.
// - Requirement on system: f_clk_i >= 4 * f_sclk; mosi stable >= SYNC_STAGES+1 clk_i cycles around sample edge.
// - FSM IDLE: synced cs_n falling edge -> SHIFT, bit_cnt=0, shift reg cleared. cs_n already low out of reset:
//   stay IDLE until a high->low transition is seen.
// - FSM SHIFT: on sample edge shift in mosi (left if MSB_FIRST, right otherwise), bit_cnt++.
//   When the sample edge hits bit_cnt==WIDTH-1: word complete, bit_cnt wraps to 0, stay SHIFT (back-to-back words).
// - SHIFT: synced cs_n rising -> IDLE; partial word discarded; frame_err_o pulses iff bit_cnt!=0.
//   cs_n rise and sample edge in same cycle: cs_n wins, edge ignored.
// - Word complete, holding empty (valid_o=0) or accepted this cycle (valid_o&ready_i): data_o<=word, valid_o=1
//   next cycle, no overrun.
// - Word complete, valid_o=1 & ready_i=0: new word dropped, data_o unchanged, overrun_o pulses 1 cycle.
// - valid_o&ready_i with no completion: valid_o=0 next cycle; data_o retains last value.
// - Latency: last sample edge at sclk_i -> valid_o high after SYNC_STAGES+2 clk_i cycles.
// - bit_cnt width $clog2(WIDTH); all counters wrap modulo WIDTH only at completion, never free-run.
// - Reset mid-frame: all state cleared per reset values; partial and held words lost, no pulses emitted.
// STRUCTURE
// - spi_pkg: typedef enum logic {IDLE, SHIFT} spi_rx_state_t; function sample_on_rise(cpol,cpha);
//   localparams for mode encodings shared with the future tx serializer.
// - Sub-module module_sync_edge_det (SYNC_STAGES, RST_VAL): synchroniser + rise/fall pulse outputs; used for
//   sclk_i and cs_n_i; mosi_i uses the synchroniser path only (same depth for alignment).
// - Top: FSM, bit counter, shift register, holding register/handshake, pulse flags.
// TESTING
// - Mode 0, WIDTH=8, MSB_FIRST=1, send 0xA5, ready_i=1 -> one valid_o pulse, data_o=0xA5, no error flags.
// - Mode 3, MSB_FIRST=0, send 0xA5 -> data_o=0xA5 (bit0 first on wire); modes 1,2 sample on falling edge, same data.
// - Back-to-back 0x3C,0xC3 in one cs_n frame, ready_i=1 -> two words in order, busy_o high throughout.
// - ready_i=0, send 0x11 then 0x22 -> data_o=0x11 held, overrun_o 1-cycle pulse at 2nd completion; ready_i=1 -> 0x11 consumed.
// - cs_n deasserted after 5 bits -> frame_err_o pulse, valid_o stays 0; next full frame 0x5A received correctly.
// - rst_i asserted after 4 bits, released with cs_n low -> no word until cs_n high->low, then 0xFF received cleanly.

Source files
------------

// File: rtl/module_spi_rx_deserializer_pkg.sv
// spi_pkg: types, SPI mode encodings and helpers shared by the SPI receive
// path and the transmit serializer that will sit next to it.
package spi_pkg;

  // Receive FSM: IDLE waits for a frame to open, SHIFT collects bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

  // Classic SPI mode numbers, encoded as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

  // Pack clock polarity and phase into a mode number.
  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

  // Modes 0 and 3 sample data on the rising sclk edge. Modes 1 and 2 sample
  // it on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    logic result;
    case (spi_mode(cpol, cpha))
      SPI_MODE_0: result = 1'b1;
      SPI_MODE_1: result = 1'b0;
      SPI_MODE_2: result = 1'b0;
      SPI_MODE_3: result = 1'b1;
      default:    result = 1'b1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/module_spi_rx_deserializer_sync_edge_det.sv
// module_sync_edge_det: multi-flop synchroniser for an asynchronous pin with
// single-cycle rise/fall pulses. The pulses are derived from the synchronised
// value and a one-cycle-delayed copy of it. Every flop resets to RST_VAL, the
// idle level of the pin, so no edge is reported immediately after reset.
module module_sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_delayed;

  // Shift the raw pin through the synchroniser chain and keep one extra copy
  // of the synchronised value so edges can be detected.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain   <= {SYNC_STAGES{RST_VAL}};
      r_delayed <= RST_VAL;
    end else begin
      r_chain   <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_delayed <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = r_chain[SYNC_STAGES-1] & ~r_delayed;
  assign o_fall = ~r_chain[SYNC_STAGES-1] & r_delayed;

endmodule

// File: rtl/module_spi_rx_deserializer.sv
// module_spi_rx_deserializer: SPI slave receive path. It synchronises the SPI
// pins, picks the sampling edge for the configured mode and assembles
// WIDTH-bit words. Each finished word goes into a one-entry holding register
// that uses a valid/ready handshake. The block also pulses a flag when a word
// is lost because the holding register was full, and another when a frame
// closes in the middle of a word.
module module_spi_rx_deserializer
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MSB_FIRST   = 1,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sclk_i,
  input  logic             cs_n_i,
  input  logic             mosi_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int               CNT_W        = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(WIDTH - 1);
  localparam int               SETTLE_W     = $clog2(SYNC_STAGES + 1);
  localparam logic             SAMPLE_LEVEL = sample_on_rise(1'(CPOL), 1'(CPHA));

  // Synchronised pins and edge events
  logic w_sclkSync;
  logic w_sclkRise;
  logic w_sclkFall;
  logic w_csSync;
  logic w_csRise;
  logic w_csFall;
  logic w_mosiSync;
  logic w_sampleEdge;

  logic [SYNC_STAGES-1:0] r_mosiChain;

  // Frame arming: no frame may start after reset until cs_n has been seen high
  logic [SETTLE_W-1:0] r_settleCnt;
  logic                w_settled;
  logic                r_armed;

  // Control FSM
  spi_rx_state_t r_state;
  spi_rx_state_t w_nextState;
  logic          w_busy;
  logic          w_frameStart;
  logic          w_frameEnd;
  logic          w_shiftEn;

  // Shift path
  logic [CNT_W-1:0] r_bitCnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_wordDone;
  logic             w_frameErr;

  // Completion stage and holding register
  logic             r_doneD;
  logic [WIDTH-1:0] r_pendWord;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_frameErr;
  logic             w_accept;
  logic             w_load;
  logic             w_overrun;

  module_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'(CPOL))
  ) u_sclkSync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_async (sclk_i),
    .o_sync  (w_sclkSync),
    .o_rise  (w_sclkRise),
    .o_fall  (w_sclkFall)
  );

  module_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_csSync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_async (cs_n_i),
    .o_sync  (w_csSync),
    .o_rise  (w_csRise),
    .o_fall  (w_csFall)
  );

  // mosi passes through a chain of the same depth as sclk. This keeps the
  // synchronised data bit aligned with the sample-edge pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mosiChain <= '0;
    end else begin
      r_mosiChain <= {r_mosiChain[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign w_mosiSync = r_mosiChain[SYNC_STAGES-1];

  // The sample edge is any synchronised sclk transition that ends at the
  // sampling level of the configured mode.
  assign w_sampleEdge = (w_sclkRise | w_sclkFall) & (w_sclkSync == SAMPLE_LEVEL);

  assign w_settled = (r_settleCnt == SETTLE_W'(SYNC_STAGES));

  // The cs_n chain starts at its preset value. Once it has flushed, seeing
  // cs_n high arms frame detection. A cs_n that is already low when reset is
  // released therefore cannot open a frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_settleCnt <= '0;
      r_armed     <= 1'b0;
    end else begin
      if (!w_settled) begin
        r_settleCnt <= r_settleCnt + SETTLE_W'(1);
      end
      r_armed <= r_armed | (w_settled & w_csSync);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: an armed cs_n fall opens a frame and a cs_n rise closes it
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_csFall && r_armed) w_nextState = SHIFT;
      SHIFT:   if (w_csRise)            w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs. If cs_n rises in the same cycle as a sample edge, the edge
  // is ignored.
  always_comb begin
    w_busy       = 1'b0;
    w_frameStart = 1'b0;
    w_frameEnd   = 1'b0;
    w_shiftEn    = 1'b0;
    case (r_state)
      IDLE: begin
        w_frameStart = w_csFall & r_armed;
      end
      SHIFT: begin
        w_busy     = 1'b1;
        w_frameEnd = w_csRise;
        w_shiftEn  = w_sampleEdge & ~w_csRise;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Next shift-register contents in the selected bit order
  always_comb begin
    w_shiftNext = r_shift;
    if (MSB_FIRST != 0) begin
      w_shiftNext = {r_shift[WIDTH-2:0], w_mosiSync};
    end else begin
      w_shiftNext = {w_mosiSync, r_shift[WIDTH-1:1]};
    end
  end

  assign w_wordDone = w_shiftEn & (r_bitCnt == LAST_BIT);
  assign w_frameErr = w_frameEnd & (r_bitCnt != '0);

  // Bit counter and shift register. Both clear when a frame opens or closes.
  // The counter wraps only when a word completes, so back-to-back words in
  // one frame stay aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else if (w_frameStart || w_frameEnd) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else if (w_shiftEn) begin
      r_shift <= w_shiftNext;
      if (w_wordDone) begin
        r_bitCnt <= '0;
      end else begin
        r_bitCnt <= r_bitCnt + CNT_W'(1);
      end
    end
  end

  // Capture each finished word in a completion stage. This frees the shift
  // register right away for the next word or frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_doneD    <= 1'b0;
      r_pendWord <= '0;
    end else begin
      r_doneD <= w_wordDone;
      if (w_wordDone) begin
        r_pendWord <= w_shiftNext;
      end
    end
  end

  assign w_accept  = r_valid & ready_i;
  assign w_load    = r_doneD & (~r_valid | ready_i);
  assign w_overrun = r_doneD & r_valid & ~ready_i;

  // Holding register with handshake. A new word may replace one that is
  // consumed in the same cycle. A word that arrives while the register is
  // still full is dropped and flagged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_overrun  <= w_overrun;
      r_frameErr <= w_frameErr;
      if (w_load) begin
        r_data  <= r_pendWord;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign overrun_o   = r_overrun;
  assign frame_err_o = r_frameErr;
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_module_spi_rx_deserializer.sv
// tb_module_spi_rx_deserializer: runs four receivers in parallel, one per SPI
// mode. Modes 0 and 1 are MSB first; modes 2 and 3 are LSB first. All four
// share cs_n, mosi and ready, and each gets sclk at its own idle polarity.
// Every wire bit is held stable across both the leading and the trailing sclk
// edge, so each receiver sees the same bit stream whatever its phase.
module tb_module_spi_rx_deserializer;

  localparam int WIDTH      = 8;
  localparam int SYNC       = 2;
  localparam int NDUT       = 4;
  localparam int CLK_PERIOD = 10;
  localparam int HALF_BIT   = 4;
  localparam int MAXW       = 256;
  // Inputs change 2 units after a rising clock edge and outputs are observed
  // on falling edges. Valid rises SYNC+2 clocks after the sample edge.
  localparam int LAT_EXP    = (SYNC + 2) * CLK_PERIOD + CLK_PERIOD / 2 - 2;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic sclkPhase = 1'b0;
  logic csN       = 1'b1;
  logic mosi      = 1'b0;
  logic ready     = 1'b1;

  logic             sclkLine  [NDUT];
  logic [WIDTH-1:0] dataO     [NDUT];
  logic             validO    [NDUT];
  logic             overrunO  [NDUT];
  logic             frameErrO [NDUT];
  logic             busyO     [NDUT];

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] gotWords    [NDUT][MAXW];
  int               gotCnt      [NDUT] = '{default: 0};
  int               overrunCnt  [NDUT] = '{default: 0};
  int               frameErrCnt [NDUT] = '{default: 0};
  int               busyLowCnt  [NDUT] = '{default: 0};
  logic             prevValid   [NDUT] = '{default: 1'b0};
  time              validRiseT  [NDUT] = '{default: 0};
  time              leadT  = 0;
  time              trailT = 0;
  logic             busyCheck = 1'b0;

  always #(CLK_PERIOD / 2) clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    assign sclkLine[g] = (g >= 2) ? ~sclkPhase : sclkPhase;
    module_spi_rx_deserializer #(
      .WIDTH       (WIDTH),
      .MSB_FIRST   ((g < 2) ? 1 : 0),
      .CPOL        (g / 2),
      .CPHA        (g % 2),
      .SYNC_STAGES (SYNC)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sclk_i      (sclkLine[g]),
      .cs_n_i      (csN),
      .mosi_i      (mosi),
      .data_o      (dataO[g]),
      .valid_o     (validO[g]),
      .ready_i     (ready),
      .overrun_o   (overrunO[g]),
      .frame_err_o (frameErrO[g]),
      .busy_o      (busyO[g])
    );
  end

  // Record every accepted word and pulse, plus when valid rises, on the falling clock edge.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (validO[k] && ready) begin
        if (gotCnt[k] < MAXW) gotWords[k][gotCnt[k]] = dataO[k];
        gotCnt[k]++;
      end
      if (overrunO[k])  overrunCnt[k]++;
      if (frameErrO[k]) frameErrCnt[k]++;
      if (busyCheck && !busyO[k]) busyLowCnt[k]++;
      if (validO[k] && !prevValid[k]) validRiseT[k] = $time;
      prevValid[k] = validO[k];
    end
  end

  // Expected word for receiver k when the wire carries w MSB first.
  function automatic logic [WIDTH-1:0] expWord(input int k, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (k < 2) return w;
    for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic frameBegin();
    csN = 1'b0;
    tick(HALF_BIT);
  endtask

  task automatic frameEnd();
    csN = 1'b1;
    tick(2 * HALF_BIT);
  endtask

  task automatic sendBit(input logic b);
    mosi = b;
    tick(HALF_BIT);
    sclkPhase = 1'b1;
    leadT = $time;
    tick(HALF_BIT);
    sclkPhase = 1'b0;
    trailT = $time;
    tick(HALF_BIT);
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; csN = 1'b1; sclkPhase = 1'b0; mosi = 1'b0; ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(SYNC + 3);
    for (int k = 0; k < NDUT; k++) begin
      total++; if (dataO[k] !== '0) begin bad++; $display("FAIL reset_data dut%0d: got %h want 00", k, dataO[k]); end
      total++; if (validO[k] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d: got %b want 0", k, validO[k]); end
      total++; if (busyO[k] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", k, busyO[k]); end
      total++; if (overrunO[k] !== 1'b0 || frameErrO[k] !== 1'b0) begin
        bad++; $display("FAIL reset_flags dut%0d: got ovr=%b ferr=%b want 0 0", k, overrunO[k], frameErrO[k]);
      end
    end
  endtask

  task automatic test_single_word(input logic [WIDTH-1:0] w);
    int  gBase [NDUT];
    int  oBase [NDUT];
    int  fBase [NDUT];
    time lastSample;
    ready = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      gBase[k] = gotCnt[k]; oBase[k] = overrunCnt[k]; fBase[k] = frameErrCnt[k];
    end
    frameBegin();
    sendWord(w);
    frameEnd();
    for (int k = 0; k < NDUT; k++) begin
      lastSample = (k % 2 == 1) ? trailT : leadT;
      total++; if (gotCnt[k] - gBase[k] !== 1) begin
        bad++; $display("FAIL single_count dut%0d w=%h: got %0d want 1", k, w, gotCnt[k] - gBase[k]);
      end
      total++; if (gotWords[k][gBase[k]] !== expWord(k, w)) begin
        bad++; $display("FAIL single_data dut%0d: got %h want %h", k, gotWords[k][gBase[k]], expWord(k, w));
      end
      total++; if (int'(validRiseT[k] - lastSample) !== LAT_EXP) begin
        bad++; $display("FAIL latency dut%0d: got %0d want %0d", k, int'(validRiseT[k] - lastSample), LAT_EXP);
      end
      total++; if (overrunCnt[k] != oBase[k] || frameErrCnt[k] != fBase[k]) begin
        bad++; $display("FAIL single_flags dut%0d: got ovr=%0d ferr=%0d want 0 0", k,
                        overrunCnt[k] - oBase[k], frameErrCnt[k] - fBase[k]);
      end
      total++; if (validO[k] !== 1'b0) begin bad++; $display("FAIL single_consumed dut%0d: got valid %b want 0", k, validO[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int gBase [NDUT];
    int bBase [NDUT];
    logic [WIDTH-1:0] words [2];
    words[0] = 8'h3C; words[1] = 8'hC3;
    ready = 1'b1;
    for (int k = 0; k < NDUT; k++) begin gBase[k] = gotCnt[k]; bBase[k] = busyLowCnt[k]; end
    frameBegin();
    busyCheck = 1'b1;
    sendWord(words[0]);
    sendWord(words[1]);
    busyCheck = 1'b0;
    frameEnd();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (gotCnt[k] - gBase[k] !== 2) begin
        bad++; $display("FAIL b2b_count dut%0d: got %0d want 2", k, gotCnt[k] - gBase[k]);
      end
      for (int i = 0; i < 2; i++) begin
        total++; if (gotWords[k][gBase[k] + i] !== expWord(k, words[i])) begin
          bad++; $display("FAIL b2b_data dut%0d word%0d: got %h want %h", k, i, gotWords[k][gBase[k] + i], expWord(k, words[i]));
        end
      end
      total++; if (busyLowCnt[k] != bBase[k]) begin
        bad++; $display("FAIL b2b_busy dut%0d: got %0d low cycles want 0", k, busyLowCnt[k] - bBase[k]);
      end
      total++; if (busyO[k] !== 1'b0) begin bad++; $display("FAIL b2b_idle dut%0d: got busy %b want 0", k, busyO[k]); end
    end
  endtask

  task automatic test_overrun();
    int gBase [NDUT];
    int oBase [NDUT];
    for (int k = 0; k < NDUT; k++) begin gBase[k] = gotCnt[k]; oBase[k] = overrunCnt[k]; end
    ready = 1'b0;
    frameBegin();
    sendWord(8'h11);
    sendWord(8'h22);
    frameEnd();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (overrunCnt[k] - oBase[k] !== 1) begin
        bad++; $display("FAIL ovr_pulse dut%0d: got %0d cycles want 1", k, overrunCnt[k] - oBase[k]);
      end
      total++; if (validO[k] !== 1'b1) begin bad++; $display("FAIL ovr_valid dut%0d: got %b want 1", k, validO[k]); end
      total++; if (dataO[k] !== expWord(k, 8'h11)) begin
        bad++; $display("FAIL ovr_held dut%0d: got %h want %h", k, dataO[k], expWord(k, 8'h11));
      end
    end
    ready = 1'b1;
    tick(3);
    for (int k = 0; k < NDUT; k++) begin
      total++; if (gotCnt[k] - gBase[k] !== 1 || gotWords[k][gBase[k]] !== expWord(k, 8'h11)) begin
        bad++; $display("FAIL ovr_consume dut%0d: got n=%0d %h want n=1 %h", k, gotCnt[k] - gBase[k],
                        gotWords[k][gBase[k]], expWord(k, 8'h11));
      end
      total++; if (validO[k] !== 1'b0) begin bad++; $display("FAIL ovr_drain dut%0d: got valid %b want 0", k, validO[k]); end
    end
  endtask

  task automatic test_frame_error();
    int gBase [NDUT];
    int fBase [NDUT];
    ready = 1'b1;
    for (int k = 0; k < NDUT; k++) begin gBase[k] = gotCnt[k]; fBase[k] = frameErrCnt[k]; end
    frameBegin();
    for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(0, 1)));
    frameEnd();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (frameErrCnt[k] - fBase[k] !== 1) begin
        bad++; $display("FAIL ferr_pulse dut%0d: got %0d cycles want 1", k, frameErrCnt[k] - fBase[k]);
      end
      total++; if (gotCnt[k] != gBase[k] || validO[k] !== 1'b0) begin
        bad++; $display("FAIL ferr_noword dut%0d: got n=%0d valid=%b want 0 0", k, gotCnt[k] - gBase[k], validO[k]);
      end
    end
    test_single_word(8'h5A);
  endtask

  task automatic test_reset_midframe();
    int gBase [NDUT];
    int fBase [NDUT];
    int oBase [NDUT];
    ready = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      gBase[k] = gotCnt[k]; fBase[k] = frameErrCnt[k]; oBase[k] = overrunCnt[k];
    end
    frameBegin();
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < NDUT; k++) begin
      total++; if (dataO[k] !== '0 || validO[k] !== 1'b0 || busyO[k] !== 1'b0) begin
        bad++; $display("FAIL rstmid_clear dut%0d: got data=%h valid=%b busy=%b want 00 0 0", k, dataO[k], validO[k], busyO[k]);
      end
    end
    sendWord(8'hFF);
    tick(HALF_BIT);
    frameEnd();
    for (int k = 0; k < NDUT; k++) begin
      total++; if (gotCnt[k] != gBase[k]) begin
        bad++; $display("FAIL rstmid_noword dut%0d: got %0d words want 0", k, gotCnt[k] - gBase[k]);
      end
      total++; if (frameErrCnt[k] != fBase[k] || overrunCnt[k] != oBase[k]) begin
        bad++; $display("FAIL rstmid_flags dut%0d: got ferr=%0d ovr=%0d want 0 0", k,
                        frameErrCnt[k] - fBase[k], overrunCnt[k] - oBase[k]);
      end
    end
    test_single_word(8'hFF);
  endtask

  task automatic test_random();
    int gBase [NDUT];
    int fBase [NDUT];
    logic [WIDTH-1:0] sent [3];
    int nWords;
    int tail;
    ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      nWords = $urandom_range(1, 3);
      tail   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIDTH - 1) : 0;
      for (int k = 0; k < NDUT; k++) begin gBase[k] = gotCnt[k]; fBase[k] = frameErrCnt[k]; end
      frameBegin();
      for (int i = 0; i < nWords; i++) begin
        sent[i] = WIDTH'($urandom);
        sendWord(sent[i]);
      end
      for (int i = 0; i < tail; i++) sendBit(1'($urandom_range(0, 1)));
      frameEnd();
      for (int k = 0; k < NDUT; k++) begin
        total++; if (gotCnt[k] - gBase[k] !== nWords) begin
          bad++; $display("FAIL rand_count it%0d dut%0d: got %0d want %0d", it, k, gotCnt[k] - gBase[k], nWords);
        end
        for (int i = 0; i < nWords; i++) begin
          total++; if (gotWords[k][gBase[k] + i] !== expWord(k, sent[i])) begin
            bad++; $display("FAIL rand_data it%0d dut%0d word%0d: got %h want %h", it, k, i,
                            gotWords[k][gBase[k] + i], expWord(k, sent[i]));
          end
        end
        total++; if (frameErrCnt[k] - fBase[k] !== ((tail != 0) ? 1 : 0)) begin
          bad++; $display("FAIL rand_ferr it%0d dut%0d: got %0d want %0d", it, k, frameErrCnt[k] - fBase[k], (tail != 0) ? 1 : 0);
        end
      end
    end
  endtask

  // Stop a run that is stuck, after reporting it.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "[TB] timeout");
  end

  // Run every scenario in sequence, then print the summary line.
  initial begin
    test_reset();
    test_single_word(8'hA5);
    test_single_word(WIDTH'($urandom));
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
